viterbi_traceback: RTL

VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

---
 rtl/viterbi_pkg.sv | 16 +
 rtl/viterbi_traceback_if.sv | 43 ++++
 rtl/viterbi_traceback.sv | 127 ++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and traceback FSM state type for the Viterbi traceback unit.
package viterbi_pkg;

    localparam int WORD_NUM     = 16;
    localparam int WORD_NUM_BIT = 4;
    localparam int POS_NUM      = 11;
    localparam int POS_NUM_BIT  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        READ = 2'd2,
        WAIT = 2'd3
    } traceback_state_e;

endpackage

// File: rtl/viterbi_traceback_if.sv
// Bus bundle for the traceback unit: start request, backpointer memory port,
// path-tag stream and status. The slave modport is the traceback engine.
interface viterbi_traceback_if
    import viterbi_pkg::*;
#(
    parameter int word_num_bit = WORD_NUM_BIT,
    parameter int POS_num_bit  = POS_NUM_BIT
);

    logic                    start;
    logic [word_num_bit:0]   sentence_len;
    logic [POS_num_bit-1:0]  best_tag;

    logic                    bp_rd_en;
    logic [word_num_bit-1:0] bp_rd_word;
    logic [POS_num_bit-1:0]  bp_rd_tag;
    logic [POS_num_bit-1:0]  bp_rd_data;

    logic [POS_num_bit-1:0]  tag_out;
    logic [word_num_bit-1:0] tag_word;
    logic                    tag_valid;
    logic                    tag_last;
    logic                    tag_ready;

    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, sentence_len, best_tag, bp_rd_data, tag_ready,
        input  bp_rd_en, bp_rd_word, bp_rd_tag,
        input  tag_out, tag_word, tag_valid, tag_last,
        input  busy, done, err
    );

    modport slave (
        input  start, sentence_len, best_tag, bp_rd_data, tag_ready,
        output bp_rd_en, bp_rd_word, bp_rd_tag,
        output tag_out, tag_word, tag_valid, tag_last,
        output busy, done, err
    );

endinterface

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: walks the backpointer memory from the last word to word 0,
// streaming one path tag per word. Optional TRACEBACK_RANGE_CHECK_EN clamps out-of-range tags.
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int word_num     = WORD_NUM,
    parameter int word_num_bit = WORD_NUM_BIT,
    parameter int POS_num      = POS_NUM,
    parameter int POS_num_bit  = POS_NUM_BIT
) (
    input  logic               clk,
    input  logic               reset_viterbi_traceback,
    viterbi_traceback_if.slave vt
);

`ifdef TRACEBACK_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    localparam logic [POS_num_bit-1:0] MaxTag = POS_num_bit'(POS_num - 1);
    localparam logic [word_num_bit:0]  MaxLen = (word_num_bit + 1)'(word_num);

    traceback_state_e        state_q, state_d;
    logic [word_num_bit-1:0] idx_q, idx_d;
    logic [POS_num_bit-1:0]  curTag_q, curTag_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    lenOk;
    logic                    bestBad;
    logic                    dataBad;
    logic                    emitActive;
    logic                    readActive;
    logic [word_num_bit-1:0] startIdx;

    assign lenOk    = (vt.sentence_len != '0) && (vt.sentence_len <= MaxLen);
    assign startIdx = word_num_bit'(vt.sentence_len - 1'b1);
    assign bestBad  = RangeCheck && (vt.best_tag > MaxTag);
    assign dataBad  = RangeCheck && (vt.bp_rd_data > MaxTag);

    always_ff @(posedge clk) begin
        if (reset_viterbi_traceback) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            curTag_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            curTag_q <= curTag_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // READ is only entered with idx_q > 0, so the decrement in WAIT cannot wrap.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        curTag_d = curTag_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (vt.start) begin
                    if (lenOk) begin
                        state_d  = EMIT;
                        idx_d    = startIdx;
                        curTag_d = bestBad ? '0 : vt.best_tag;
                        if (bestBad) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (vt.tag_ready) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d  = EMIT;
                idx_d    = idx_q - 1'b1;
                curTag_d = dataBad ? '0 : vt.bp_rd_data;
                if (dataBad) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign emitActive = (state_q == EMIT);
    assign readActive = (state_q == READ);

    // Data outputs are forced to zero whenever their strobe is low.
    assign vt.tag_valid  = emitActive;
    assign vt.tag_out    = emitActive ? curTag_q : '0;
    assign vt.tag_word   = emitActive ? idx_q : '0;
    assign vt.tag_last   = emitActive && (idx_q == '0);

    assign vt.bp_rd_en   = readActive;
    assign vt.bp_rd_word = readActive ? idx_q : '0;
    assign vt.bp_rd_tag  = readActive ? curTag_q : '0;

    assign vt.busy       = (state_q != IDLE);
    assign vt.done       = done_q;
    assign vt.err        = err_q;

endmodule
